// File: rtl/rr_buffer_ctrl_pkg.sv
//==============================================================================
// Module      : rr_buffer_ctrl_pkg
// Description : Shared definitions for the round-robin buffer controller:
//               FSM state encoding, default sizing constants and a small
//               modulo-increment helper for the round-robin pointer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rr_buffer_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_NUM_REQ = 4;

  // (idx + 1) mod n without a divider; idx is always < n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin arbiter. Searches upward from
//               ptr_i (modulo NumReq) and grants the first active request.
// Ports       : req_i   - request vector
//               ptr_i   - highest-priority index for this search
//               grant_o - one-hot grant, zero when no request is active
//               idx_o   - encoded index of the granted request
//               any_o   - at least one request active
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int NumReq = 4,
  localparam int SrcW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [SrcW-1:0]   ptr_i,
  output logic [NumReq-1:0] grant_o,
  output logic [SrcW-1:0]   idx_o,
  output logic              any_o
);

  int              k;
  logic [SrcW-1:0] k_idx;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = 0;
    k_idx   = '0;
    for (int i = 0; i < NumReq; i++) begin
      k     = (int'(ptr_i) + i) % NumReq;
      k_idx = SrcW'(k);
      // Only the first hit in search order is taken.
      if (!any_o && req_i[k_idx]) begin
        grant_o[k_idx] = 1'b1;
        idx_o          = k_idx;
        any_o          = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_buffer_ctrl.sv
//==============================================================================
// Module      : rr_buffer_ctrl
// Description : Shares one Width-bit holding register between NumReq
//               requesters. A round-robin arbiter picks a valid requester, its
//               data is captured and presented downstream with valid/ready
//               and the source index.
//               Optional macro RR_BUFFER_CTRL_FASTPATH_EN: when defined, the
//               register is refilled in the same cycle it is drained, giving
//               one transfer per cycle.
// Ports       : clk_i        - clock, rising edge
//               rst_i        - synchronous active-high reset
//               clear_i      - flush buffer and zero the register
//               req_valid_i  - per-requester valid
//               req_data_i   - requester k data at [k*Width +: Width]
//               req_ready_o  - one-hot grant to requesters
//               out_valid_o  - register holds unconsumed data
//               out_data_o   - register contents
//               out_src_o    - requester index of held data
//               out_ready_i  - consumer accepts data
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_buffer_ctrl
  import rr_buffer_ctrl_pkg::*;
#(
  parameter  int Width  = DEFAULT_WIDTH,
  parameter  int NumReq = DEFAULT_NUM_REQ,
  localparam int SrcW   = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq*Width-1:0] req_data_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic                    out_valid_o,
  output logic [Width-1:0]        out_data_o,
  output logic [SrcW-1:0]         out_src_o,
  input  logic                    out_ready_i
);

  state_e            state_q, state_d;
  logic [Width-1:0]  data_q, data_d;
  logic [SrcW-1:0]   src_q, src_d;
  logic [SrcW-1:0]   ptr_q, ptr_d;
  logic              load;

  logic [NumReq-1:0] arb_grant;
  logic [SrcW-1:0]   arb_idx;
  logic              arb_any;

  logic [Width-1:0]  req_data_arr [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign req_data_arr[g] = req_data_i[g*Width +: Width];
  end

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    src_d       = src_q;
    ptr_d       = ptr_q;
    req_ready_o = '0;
    load        = 1'b0;

    if (rst_i || clear_i) begin
      // No grant while flushing, so a requester never sees a handshake
      // whose data is thrown away. Reset itself is applied in the flops.
      state_d = ST_EMPTY;
      data_d  = '0;
      src_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          req_ready_o = arb_grant;
          load        = arb_any;
        end
        ST_FULL: begin
          if (out_ready_i) begin
            state_d = ST_EMPTY;
`ifdef RR_BUFFER_CTRL_FASTPATH_EN
            // Refill in the drain cycle; load overrides the EMPTY transition.
            req_ready_o = arb_grant;
            load        = arb_any;
`endif
          end
        end
        default: state_d = ST_EMPTY;
      endcase

      if (load) begin
        state_d = ST_FULL;
        data_d  = req_data_arr[arb_idx];
        src_d   = arb_idx;
        ptr_d   = SrcW'(wrap_inc(int'(arb_idx), NumReq));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid_o = (state_q == ST_FULL);
  assign out_data_o  = data_q;
  assign out_src_o   = src_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_buffer_ctrl.sv
//==============================================================================
// Module      : tb_rr_buffer_ctrl
// Description : Self-checking bench for rr_buffer_ctrl. A transaction-level
//               reference model predicts accepted requester items into a
//               scoreboard queue; a monitor pops and compares on every
//               downstream handshake. Directed scenarios are followed by
//               randomized traffic. Honours RR_BUFFER_CTRL_FASTPATH_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rr_buffer_ctrl;

  localparam int N = 4;
  localparam int W = 8;
`ifdef RR_BUFFER_CTRL_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_buffer_ctrl #(.Width(W), .NumReq(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .out_ready_i (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] d;
    int           s;
  } item_t;

  item_t        sb[$];
  logic [W-1:0] consumed[$];
  int           m_ptr  = 0;
  bit           m_full = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_src  = 0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic bit may_accept();
    return !rst && !clear && (!m_full || (FAST && out_ready));
  endfunction

  always @(posedge clk) begin
    int    w;
    item_t it;
    w = pick(req_valid, m_ptr);
    if (rst) begin
      m_full = 1'b0; m_ptr = 0; m_data = '0; m_src = 0;
      sb.delete();
    end else if (clear) begin
      if (m_full && sb.size() > 0) void'(sb.pop_back());
      m_full = 1'b0; m_data = '0; m_src = 0;
    end else if (may_accept()) begin
      if (w >= 0) begin
        it.d = req_data[w*W +: W];
        it.s = w;
        sb.push_back(it);
        m_data = it.d; m_src = w; m_ptr = (w + 1) % N; m_full = 1'b1;
      end else begin
        m_full = 1'b0;
      end
    end else if (out_ready) begin
      m_full = 1'b0;
    end
  end

  // Cycle-level checks of visible state against the model.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int           w;
    exp_rdy = '0;
    w = pick(req_valid, m_ptr);
    if (may_accept() && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_src",   32'(out_src),   32'(m_src));
  end

  // Scoreboard monitor: compares on every presented output.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        chk("sb_data", 32'(out_data), 32'(sb[0].d));
        chk("sb_src",  32'(out_src),  32'(sb[0].s));
        if (out_ready && !clear && !rst) begin
          consumed.push_back(out_data);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] hs;
    rst = 1'b1; clear = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    tick(); tick();

    // Reset held with all requesters valid: nothing granted or presented.
    req_valid = 4'hF;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      tick();
    end

    // Round-robin over four held requesters.
    rst = 1'b0; out_ready = 1'b1;
    consumed.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) chk("first_grant", 32'(req_ready), 32'b0001);
      if (i < 8) chk("valid_pattern", 32'(out_valid), FAST ? 32'(i >= 1) : 32'(i % 2));
      tick();
    end
    chk("seq_len", 32'(consumed.size() >= 5), 32'd1);
    chk("seq0", 32'(consumed[0]), 32'h10);
    chk("seq1", 32'(consumed[1]), 32'h11);
    chk("seq2", 32'(consumed[2]), 32'h12);
    chk("seq3", 32'(consumed[3]), 32'h13);
    chk("seq4", 32'(consumed[4]), 32'h10);
    req_valid = '0;
    tick(); tick();

    // Single requester 2 held by a stalled consumer, then pointer wrap 3 -> 0.
    consumed.delete();
    out_ready = 1'b0;
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    @(negedge clk);
    chk("grant2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1001;
    req_data  = {8'hC3, 8'h00, 8'h00, 8'hC0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data",  32'(out_data),  32'hA5);
      chk("stall_src",   32'(out_src),   32'd2);
      chk("stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("wrap_len", 32'(consumed.size() >= 3), 32'd1);
    chk("wrap0", 32'(consumed[0]), 32'hA5);
    chk("wrap1", 32'(consumed[1]), 32'hC3);
    chk("wrap2", 32'(consumed[2]), 32'hC0);
    req_valid = '0;
    tick(); tick();

    // Clear while FULL: pending data dropped, requester 1 granted afterwards.
    out_ready = 1'b0;
    req_valid = 4'b0010;
    req_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
    tick();
    req_data  = {8'h00, 8'h00, 8'h77, 8'h00};
    clear     = 1'b1;
    @(negedge clk);
    chk("clr_full_data", 32'(out_data), 32'h5A);
    chk("clr_no_grant",  32'(req_ready), 32'd0);
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_data",  32'(out_data),  32'd0);
    chk("clr_src",   32'(out_src),   32'd0);
    chk("clr_regrant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0; out_ready = 1'b1;
    tick(); tick();

    // Clear together with out_ready in FULL: no grant, ends EMPTY and zeroed.
    out_ready = 1'b0;
    req_valid = 4'b0001;
    req_data  = {8'h00, 8'h00, 8'h00, 8'h66};
    tick();
    req_data  = {8'h00, 8'h00, 8'h00, 8'h67};
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("clr_rdy_no_grant", 32'(req_ready), 32'd0);
    tick();
    clear = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("clr_rdy_valid", 32'(out_valid), 32'd0);
    chk("clr_rdy_data",  32'(out_data),  32'd0);
    tick();

    // Randomized traffic with well-behaved requesters.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      tick();
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] || hs[k]) begin
          req_valid[k]         = ($urandom_range(0, 99) < 60);
          req_data[k*W +: W]   = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      clear     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
    end

    rst = 1'b0; clear = 1'b0; req_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
